// File: rtl/clk_skew_stage.sv
// Skewed sampling stage: delayed input capture into a 2-deep FIFO,
// plus an independent fixed-delay output drive path.
module clk_skew_stage #(
  parameter int WIDTH    = 8,
  parameter int IN_SKEW  = 2,
  parameter int OUT_SKEW = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             smp_valid,
  output logic [WIDTH-1:0] smp_data,
  input  logic             smp_ready,
  input  logic             drv_valid,
  input  logic [WIDTH-1:0] drv_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             busy
);

  logic [IN_SKEW-1:0]  iv;
  logic [WIDTH-1:0]    id [IN_SKEW];
  logic [OUT_SKEW-1:0] ov;
  logic [WIDTH-1:0]    od [OUT_SKEW];

  logic [WIDTH-1:0]    mem [2];
  logic                wp;
  logic                rp;
  logic [1:0]          cnt;
  logic [CNT_W-1:0]    ovf_q;

  logic                tail_v;
  logic [WIDTH-1:0]    tail_d;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  // Input skew line; data zeroed on idle slots so it never leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv <= '0;
      for (int i = 0; i < IN_SKEW; i++)
        id[i] <= '0;
    end else begin
      iv[0] <= in_valid;
      id[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < IN_SKEW; i++) begin
        iv[i] <= iv[i-1];
        id[i] <= id[i-1];
      end
    end
  end

  assign tail_v = iv[IN_SKEW-1];
  assign tail_d = id[IN_SKEW-1];

  assign full   = (cnt == 2'd2);
  assign pop    = smp_valid & smp_ready;
  assign push   = tail_v & (~full | pop);
  assign drop   = tail_v & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
      ovf_q  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= tail_d;
        wp      <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (drop && (ovf_q != '1))
        ovf_q <= ovf_q + CNT_W'(1);
    end
  end

  assign smp_valid = (cnt != 2'd0);
  assign smp_data  = smp_valid ? mem[rp] : '0;
  assign ovf_cnt   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov <= '0;
      for (int i = 0; i < OUT_SKEW; i++)
        od[i] <= '0;
    end else begin
      ov[0] <= drv_valid;
      od[0] <= drv_valid ? drv_data : '0;
      for (int i = 1; i < OUT_SKEW; i++) begin
        ov[i] <= ov[i-1];
        od[i] <= od[i-1];
      end
    end
  end

  assign out_valid = ov[OUT_SKEW-1];
  assign out_data  = out_valid ? od[OUT_SKEW-1] : '0;

  assign busy = (|iv) | smp_valid | (|ov);

endmodule

// File: tb/tb_clk_skew_stage.sv
// Bench for clk_skew_stage: history-based model of two instances
// (defaults, and OUT_SKEW=3/CNT_W=2) plus directed literal checks.
module tb_clk_skew_stage;

  localparam int NC = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       smp_ready = 1'b0;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_data = '0;

  logic       sv_a, ov_a, bz_a;
  logic [7:0] sd_a, od_a, ovf_a;
  logic       sv_b, ov_b, bz_b;
  logic [7:0] sd_b, od_b;
  logic [1:0] ovf_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_skew_stage u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .smp_valid(sv_a), .smp_data(sd_a), .smp_ready(smp_ready),
    .drv_valid(drv_valid), .drv_data(drv_data),
    .out_valid(ov_a), .out_data(od_a),
    .ovf_cnt(ovf_a), .busy(bz_a)
  );

  clk_skew_stage #(
    .WIDTH(8), .IN_SKEW(2), .OUT_SKEW(3), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .smp_valid(sv_b), .smp_data(sd_b), .smp_ready(smp_ready),
    .drv_valid(drv_valid), .drv_data(drv_data),
    .out_valid(ov_b), .out_data(od_b),
    .ovf_cnt(ovf_b), .busy(bz_b)
  );

  // Model: input/drive history per cycle, FIFO as a queue.
  int         is_p [2] = '{2, 2};
  int         os_p [2] = '{1, 3};
  int         cmax [2] = '{255, 3};
  logic       h_iv [NC];
  logic [7:0] h_id [NC];
  logic       h_dv [NC];
  logic [7:0] h_dd [NC];
  logic [7:0] mq [2][$];
  int         movf [2] = '{0, 0};
  int         cyc = 0;
  int         last_rst = -1000;

  function automatic bit live_in(int t);
    return t >= 0 && t > last_rst && h_iv[t];
  endfunction

  function automatic bit live_dv(int t);
    return t >= 0 && t > last_rst && h_dv[t];
  endfunction

  always @(posedge clk) begin
    int c;
    int t;
    bit pp;
    c = cyc;
    if (c < NC) begin
      h_iv[c] = in_valid;
      h_id[c] = in_data;
      h_dv[c] = drv_valid;
      h_dd[c] = drv_data;
    end
    if (rst) begin
      last_rst = c;
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        movf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        t  = c - is_p[k];
        pp = (mq[k].size() > 0) && smp_ready;
        if (pp)
          void'(mq[k].pop_front());
        if (live_in(t)) begin
          if (mq[k].size() == 2) begin
            if (movf[k] < cmax[k])
              movf[k]++;
          end else begin
            mq[k].push_back(h_id[t]);
          end
        end
      end
    end
    cyc = c + 1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    bit e_sv, e_ov, e_bz;
    logic [7:0] e_sd, e_od;
    logic [7:0] a_sd [2];
    logic [7:0] a_od [2];
    logic a_sv [2];
    logic a_ov [2];
    logic a_bz [2];
    logic [7:0] a_ovf [2];
    n = cyc;
    a_sv[0] = sv_a; a_sd[0] = sd_a; a_ov[0] = ov_a;
    a_od[0] = od_a; a_bz[0] = bz_a; a_ovf[0] = ovf_a;
    a_sv[1] = sv_b; a_sd[1] = sd_b; a_ov[1] = ov_b;
    a_od[1] = od_b; a_bz[1] = bz_b; a_ovf[1] = {6'd0, ovf_b};
    for (int k = 0; k < 2; k++) begin
      e_sv = mq[k].size() > 0;
      e_sd = e_sv ? mq[k][0] : 8'h00;
      e_ov = live_dv(n - os_p[k]);
      e_od = e_ov ? h_dd[n - os_p[k]] : 8'h00;
      e_bz = e_sv;
      for (int j = 1; j <= is_p[k]; j++)
        if (live_in(n - j)) e_bz = 1'b1;
      for (int j = 1; j <= os_p[k]; j++)
        if (live_dv(n - j)) e_bz = 1'b1;
      chk($sformatf("m%0d.smp_valid", k), 32'(a_sv[k]), 32'(e_sv));
      chk($sformatf("m%0d.smp_data", k), 32'(a_sd[k]), 32'(e_sd));
      chk($sformatf("m%0d.out_valid", k), 32'(a_ov[k]), 32'(e_ov));
      chk($sformatf("m%0d.out_data", k), 32'(a_od[k]), 32'(e_od));
      chk($sformatf("m%0d.ovf_cnt", k), 32'(a_ovf[k]), 32'(movf[k]));
      chk($sformatf("m%0d.busy", k), 32'(a_bz[k]), 32'(e_bz));
    end
  end

  task automatic step(input logic v, input logic [7:0] d,
                      input logic r, input logic dv,
                      input logic [7:0] dd, input logic rs = 1'b0);
    rst       = rs;
    in_valid  = v;
    in_data   = d;
    smp_ready = r;
    drv_valid = dv;
    drv_data  = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("rst.smp_valid", 32'(sv_a), 0);
    chk("rst.smp_data", 32'(sd_a), 0);
    chk("rst.out_valid", 32'(ov_a), 0);
    chk("rst.out_data", 32'(od_a), 0);
    chk("rst.ovf", 32'(ovf_a), 0);
    chk("rst.busy", 32'(bz_a), 0);

    // latency: sample in cycle t shows up in t+3 only
    step(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat.early", 32'(sv_a), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat.valid", 32'(sv_a), 1);
    chk("lat.data", 32'(sd_a), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat.once", 32'(sv_a), 0);

    // overflow: four samples, stalled consumer
    for (int i = 1; i <= 4; i++)
      step(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf.cnt_a", 32'(ovf_a), 2);
    chk("ovf.cnt_b", 32'(ovf_b), 2);
    chk("ovf.head1", 32'(sd_a), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf.head2", 32'(sd_a), 2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf.empty", 32'(sv_a), 0);

    // full FIFO, push 0x33 while popping
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("fullpop.head", 32'(sd_a), 32'h11);
    chk("fullpop.ovf", 32'(ovf_a), 2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("fullpop.next", 32'(sd_a), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("fullpop.empty", 32'(sv_a), 0);

    // output skew on the OUT_SKEW=3 instance
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h5B);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("oskew.v13", 32'(ov_b), 1);
    chk("oskew.d13", 32'(od_b), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("oskew.d14", 32'(od_b), 32'h5B);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("oskew.v15", 32'(ov_b), 0);
    chk("oskew.d15", 32'(od_b), 0);

    // saturation: six drops after reset
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("sat.b", 32'(ovf_b), 3);
    chk("sat.a", 32'(ovf_a), 6);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // reset with samples and a drive in flight
    step(1'b1, 8'h77, 1'b0, 1'b1, 8'h99);
    step(1'b1, 8'h78, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h79, 1'b0, 1'b1, 8'hAA, 1'b1);
    @(negedge clk);
    chk("mrst.busy_a", 32'(bz_a), 0);
    chk("mrst.busy_b", 32'(bz_b), 0);
    chk("mrst.out_b", 32'(ov_b), 0);
    chk("mrst.ovf_a", 32'(ovf_a), 0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("mrst.later_sv", 32'(sv_a), 0);
    chk("mrst.later_bz", 32'(bz_b), 0);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom));
    repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_skew_stage.md
CLK_SKEW_STAGE -- requirements
Module: clk_skew_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data width of both paths.
REQ-002 The block SHALL have parameter IN_SKEW, default 2, the input-sampling delay in cycles (legal 1..8).
REQ-003 The block SHALL have parameter OUT_SKEW, default 1, the output-drive delay in cycles (legal 1..8).
REQ-004 The block SHALL have parameter CNT_W, default 8, the width of the overflow counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: raw input sample present this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: raw input sample.
REQ-009 The block SHALL have port smp_valid, output, 1 bit: skewed sample available to the consumer.
REQ-010 The block SHALL have port smp_data, output, WIDTH bits: skewed sample.
REQ-011 The block SHALL have port smp_ready, input, 1 bit: the consumer accepts smp_data this cycle.
REQ-012 The block SHALL have port drv_valid, input, 1 bit: the consumer requests an output drive.
REQ-013 The block SHALL have port drv_data, input, WIDTH bits: the value to drive.
REQ-014 The block SHALL have port out_valid, output, 1 bit: the skewed drive is active.
REQ-015 The block SHALL have port out_data, output, WIDTH bits: the skewed drive value.
REQ-016 The block SHALL have port ovf_cnt, output, CNT_W bits: saturating count of dropped samples.
REQ-017 The block SHALL have port busy, output, 1 bit: any valid entry in flight anywhere in the block.

Function
REQ-018 The input path SHALL be an IN_SKEW-stage valid/data shift register that advances every cycle unconditionally and cannot be stalled.
REQ-019 The tail of the input shift register SHALL push into a 2-entry FIFO when the tail valid bit is 1.
REQ-020 smp_valid SHALL equal FIFO-not-empty, and smp_data SHALL equal the FIFO head; smp_data SHALL be 0 when smp_valid is 0.
REQ-021 The FIFO SHALL pop when smp_valid and smp_ready are both 1 in the same cycle.
REQ-022 With the FIFO empty and smp_ready=1, a sample with in_valid=1 in cycle t SHALL appear with smp_valid=1 in cycle t+IN_SKEW+1.
REQ-023 A push with the FIFO full and no pop in the same cycle SHALL be dropped, and ovf_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-024 A push with the FIFO full and a pop in the same cycle SHALL be accepted with no drop; the occupancy SHALL stay 2.
REQ-025 A simultaneous push and pop with the FIFO empty SHALL NOT bypass; the occupancy SHALL become 1 and the new entry SHALL be presented next cycle.
REQ-026 The FIFO SHALL preserve order; its pointers SHALL wrap modulo 2.
REQ-027 The output path SHALL be an OUT_SKEW-stage valid/data shift register that advances every cycle unconditionally.
REQ-028 drv_valid=1 in cycle t SHALL produce out_valid=1 with out_data=drv_data in cycle t+OUT_SKEW.
REQ-029 out_data SHALL be 0 whenever out_valid is 0.
REQ-030 Back-to-back drives SHALL yield back-to-back outputs with no bubbles.
REQ-031 busy SHALL be the OR of all input-stage valid bits, FIFO-not-empty and all output-stage valid bits, and SHALL be combinational from state.
REQ-032 The input and output paths SHALL be independent; activity on one SHALL NOT affect timing on the other.

Reset
REQ-033 While rst=1 at posedge clk, all valid bits SHALL clear, all data registers SHALL load 0, the FIFO SHALL empty, and ovf_cnt SHALL clear to 0.
REQ-034 In the cycle after reset, smp_valid, smp_data, out_valid, out_data, ovf_cnt and busy SHALL all be 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight samples and drives without incrementing ovf_cnt.
REQ-036 Inputs presented in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-037 Latency check: defaults, smp_ready=1, in_valid=1 with in_data=0xA5 in cycle 5 -> smp_valid=1 and smp_data=0xA5 in cycle 8 only.
REQ-038 Overflow check: smp_ready=0, four consecutive samples 0x01..0x04 -> FIFO holds 0x01,0x02; ovf_cnt=2; then smp_ready=1 -> 0x01 then 0x02 delivered.
REQ-039 Full with simultaneous pop: FIFO full, push 0x33 while popping -> no drop, ovf_cnt unchanged, order preserved.
REQ-040 Output skew check: OUT_SKEW=3, drv_valid=1 with drv_data=0x5A, 0x5B in cycles 10-11 -> out_data=0x5A in cycle 13 and 0x5B in cycle 14, out_data=0 in cycle 15.
REQ-041 Saturation check: CNT_W=2, six drops -> ovf_cnt holds at 3.
REQ-042 Reset mid-flight: rst=1 while 2 samples and 1 drive are in flight -> all outputs 0 next cycle, busy=0, nothing later emerges.
